round_robin_demux: RTL and testbench
====================================

Name: round_robin_demux

Overview:
Inverse of the team's select-based mux: one upstream valid/ready stream is distributed across N_OUT downstream lanes in strict round-robin order (beat 0 to lane 0, beat 1 to lane 1, ... then wrap). Each lane has a one-entry registered output buffer, so a slow lane stalls only when its own turn comes. It sits between a single producer and N_OUT parallel consumers, such as worker units or per-channel sinks.

Parameters:
WIDTH, 8, data bits per beat (>=1)
N_OUT, 4, number of output lanes (>=2; need not be a power of 2)
PTR_W, $clog2(N_OUT), lane pointer width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
up_valid  input  1  upstream beat present
up_ready  output  1  block can accept the beat this cycle
up_data  input  WIDTH  upstream payload
down_valid  output  N_OUT  bit i: lane i buffer holds a beat
down_ready  input  N_OUT  bit i: lane i consumer accepts this cycle
down_data  output  N_OUT*WIDTH  lane i payload at bits [i*WIDTH +: WIDTH]
sel_ptr  output  PTR_W  lane that receives the next accepted beat

Behaviour:
- State: ptr (PTR_W bits); per lane: full[i] (1 bit) and buf[i] (WIDTH bits).
- Reset (rst=1 at posedge):
  - ptr=0, all full=0, all buf=0.
  - Next cycle outputs: down_valid=0, down_data=0, sel_ptr=0.
  - Reset dominates every other event in that cycle. Beats buffered when reset hits mid-stream are discarded.
- Outputs:
  - down_valid[i]=full[i]; down_data lane i = buf[i]; sel_ptr=ptr. All are driven from registers only.
  - up_ready = !full[ptr] | down_ready[ptr]. This is combinational: the lane drains and refills in the same cycle.
  - up_ready does not depend on up_valid.
- Accept: up_valid & up_ready at posedge.
  - buf[ptr] <= up_data; full[ptr] <= 1.
  - ptr <= (ptr==N_OUT-1) ? 0 : ptr+1. Wrap at N_OUT-1 for every N_OUT, including non-power-of-2.
- Drain: down_valid[i] & down_ready[i] at posedge clears full[i], unless lane i is also being loaded that cycle (load wins: full stays 1 and buf takes the new data).
- Multiple lanes may drain in the same cycle, independently of the accept.
- Latency:
  - Beat accepted at cycle t appears on its lane at t+1.
  - Sustained throughput is 1 beat/cycle when every consumer keeps down_ready=1.
- Ordering:
  - Lanes are never skipped. If lane ptr is full and not draining, up_ready=0 and ptr holds, even if other lanes are empty.
  - Global beat k always lands on lane k mod N_OUT.
- Stability: a lane with down_valid=1 and down_ready=0 keeps down_valid and its data unchanged until drained.
- up_valid=0: no state change except drains.
- X on up_data while up_valid=0 must not reach any buf.

Test Plan:
1. Reset, then all down_ready=1 and 8 back-to-back beats 0x10..0x17 -> lanes 0..3 get 0x10,0x11,0x12,0x13, then 0x14..0x17, each one cycle after accept. up_ready stays 1 throughout. sel_ptr sequence is 0,1,2,3,0,1,2,3,0.
2. down_ready=0 on all lanes, send 5 beats 0xA0..0xA4 -> 0xA0..0xA3 accepted in 4 cycles. Then up_ready=0 with sel_ptr=0 and 0xA4 held. Raise down_ready[0] alone -> 0xA4 accepted that same cycle. Lane 0 shows 0xA4 next cycle with down_valid[0] still 1.
3. Lane 2 stalled (down_ready[2]=0), others ready, continuous stream -> 3rd and 7th beats: the 7th blocks at sel_ptr=2 while lanes 0,1,3 are empty. No beat is routed to lane 3 early. Release lane 2 -> the stream resumes in order.
4. Set N_OUT=3, WIDTH=4, stream 0x1..0x7 with all ready -> lanes receive 1,4,7 / 2,5 / 3,6. sel_ptr wraps 2->0 and never reads 3.
5. Assert rst for 1 cycle while lanes 1 and 3 hold 0x55 and 0x66 undrained -> next cycle: down_valid=0000, down_data=0, sel_ptr=0. First post-reset beat goes to lane 0.
6. Random up_valid/down_ready (50%) over 2000 beats, with a scoreboard per lane -> every beat k arrives on lane k mod N_OUT in order. No loss or duplication. Lane data never changes while down_valid=1 and down_ready=0.

Source files
------------

// File: rtl/round_robin_demux.sv
// Round-robin demultiplexer: one valid/ready stream is dealt out to N_OUT lanes
// in strict rotation. Each lane has a one-entry registered output buffer.
module round_robin_demux #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  localparam int PTR_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [WIDTH-1:0]       up_data,
  output logic [N_OUT-1:0]       down_valid,
  input  logic [N_OUT-1:0]       down_ready,
  output logic [N_OUT*WIDTH-1:0] down_data,
  output logic [PTR_W-1:0]       sel_ptr
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [N_OUT-1:0] full;
  logic [WIDTH-1:0] lane_buf [N_OUT];
  logic             accept;

  // The current lane may drain and refill in the same cycle, so a ready consumer
  // never costs a bubble. Other lanes are never considered, even when empty.
  assign up_ready = !full[ptr] || down_ready[ptr];
  assign accept   = up_valid && up_ready;

  // Explicit wrap so non-power-of-2 lane counts never reach an unused pointer value.
  assign ptr_next = (ptr == PTR_W'(N_OUT - 1)) ? '0 : ptr + PTR_W'(1);

  assign down_valid = full;
  assign sel_ptr    = ptr;

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane_out
    assign down_data[g*WIDTH +: WIDTH] = lane_buf[g];
  end

  // A load into a lane takes priority over its drain in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      full <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        lane_buf[i] <= '0;
      end
    end else begin
      if (accept) begin
        ptr <= ptr_next;
      end
      for (int i = 0; i < N_OUT; i++) begin
        if (accept && (ptr == PTR_W'(i))) begin
          full[i]     <= 1'b1;
          lane_buf[i] <= up_data;
        end else if (full[i] && down_ready[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_robin_demux.sv
// Self-checking bench for round_robin_demux: a 4-lane 8-bit instance and a
// 3-lane 4-bit instance, directed scenarios plus a randomized scoreboard run.
module tb_round_robin_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [7:0]  up_data = '0;
  logic [3:0]  down_valid;
  logic [3:0]  down_ready = '0;
  logic [31:0] down_data;
  logic [1:0]  sel_ptr;

  logic        up_valid3 = 1'b0;
  logic        up_ready3;
  logic [3:0]  up_data3 = '0;
  logic [2:0]  down_valid3;
  logic [2:0]  down_ready3 = '0;
  logic [11:0] down_data3;
  logic [1:0]  sel_ptr3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  round_robin_demux #(.WIDTH(8), .N_OUT(4)) dut4 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
    .sel_ptr(sel_ptr)
  );

  round_robin_demux #(.WIDTH(4), .N_OUT(3)) dut3 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid3), .up_ready(up_ready3), .up_data(up_data3),
    .down_valid(down_valid3), .down_ready(down_ready3), .down_data(down_data3),
    .sel_ptr(sel_ptr3)
  );

  // Inputs change 1 time unit after each rising edge, well away from the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    up_valid = 1'b0;
    up_valid3 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    down_ready = '0;
    down_ready3 = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (down_valid !== 4'b0) $display("[TB] FAIL reset_valid: got %b, expected 0000", down_valid); else passed++;
    checks++; if (down_data !== 32'h0) $display("[TB] FAIL reset_data: got %h, expected 0", down_data); else passed++;
    checks++; if (sel_ptr !== 2'd0) $display("[TB] FAIL reset_ptr: got %0d, expected 0", sel_ptr); else passed++;
    checks++; if (up_ready !== 1'b1) $display("[TB] FAIL reset_ready_idle: got %b, expected 1", up_ready); else passed++;
    up_valid = 1'b1;
    #1;
    checks++; if (up_ready !== 1'b1) $display("[TB] FAIL reset_ready_valid: got %b, expected 1", up_ready); else passed++;
    up_valid = 1'b0;
    checks++; if (down_valid3 !== 3'b0) $display("[TB] FAIL reset3_valid: got %b, expected 000", down_valid3); else passed++;
    checks++; if (down_data3 !== 12'h0) $display("[TB] FAIL reset3_data: got %h, expected 0", down_data3); else passed++;
    checks++; if (sel_ptr3 !== 2'd0) $display("[TB] FAIL reset3_ptr: got %0d, expected 0", sel_ptr3); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] expd;
    down_ready = 4'hF;
    for (int b = 0; b < 8; b++) begin
      up_valid = 1'b1;
      up_data  = 8'h10 + 8'(b);
      #1;
      checks++; if (up_ready !== 1'b1) $display("[TB] FAIL b2b_ready beat %0d: got %b, expected 1", b, up_ready); else passed++;
      checks++; if (sel_ptr !== 2'(b % 4)) $display("[TB] FAIL b2b_ptr beat %0d: got %0d, expected %0d", b, sel_ptr, b % 4); else passed++;
      tick();
      expd = 8'h10 + 8'(b);
      checks++; if (down_valid !== (4'b1 << (b % 4))) $display("[TB] FAIL b2b_valid beat %0d: got %b, expected %b", b, down_valid, 4'b1 << (b % 4)); else passed++;
      checks++; if (down_data[(b % 4)*8 +: 8] !== expd) $display("[TB] FAIL b2b_data beat %0d: got %h, expected %h", b, down_data[(b % 4)*8 +: 8], expd); else passed++;
    end
    up_valid = 1'b0;
    checks++; if (sel_ptr !== 2'd0) $display("[TB] FAIL b2b_ptr_end: got %0d, expected 0", sel_ptr); else passed++;
    tick();
    checks++; if (down_valid !== 4'b0) $display("[TB] FAIL b2b_drained: got %b, expected 0000", down_valid); else passed++;
  endtask

  task automatic test_all_stalled();
    down_ready = 4'b0;
    for (int b = 0; b < 4; b++) begin
      up_valid = 1'b1;
      up_data  = 8'hA0 + 8'(b);
      #1;
      checks++; if (up_ready !== 1'b1) $display("[TB] FAIL stall_fill_ready beat %0d: got %b, expected 1", b, up_ready); else passed++;
      tick();
    end
    up_data = 8'hA4;
    for (int h = 0; h < 2; h++) begin
      #1;
      checks++; if (up_ready !== 1'b0) $display("[TB] FAIL stall_blocked_ready: got %b, expected 0", up_ready); else passed++;
      checks++; if (sel_ptr !== 2'd0) $display("[TB] FAIL stall_blocked_ptr: got %0d, expected 0", sel_ptr); else passed++;
      checks++; if (down_valid !== 4'hF) $display("[TB] FAIL stall_blocked_valid: got %b, expected 1111", down_valid); else passed++;
      checks++; if (down_data !== 32'hA3A2A1A0) $display("[TB] FAIL stall_blocked_data: got %h, expected a3a2a1a0", down_data); else passed++;
      tick();
    end
    down_ready = 4'b0001;
    #1;
    checks++; if (up_ready !== 1'b1) $display("[TB] FAIL stall_release_ready: got %b, expected 1", up_ready); else passed++;
    tick();
    up_valid = 1'b0;
    down_ready = 4'b0;
    checks++; if (down_valid !== 4'hF) $display("[TB] FAIL stall_refill_valid: got %b, expected 1111", down_valid); else passed++;
    checks++; if (down_data[7:0] !== 8'hA4) $display("[TB] FAIL stall_refill_data: got %h, expected a4", down_data[7:0]); else passed++;
    checks++; if (sel_ptr !== 2'd1) $display("[TB] FAIL stall_refill_ptr: got %0d, expected 1", sel_ptr); else passed++;
    down_ready = 4'hF;
    tick();
    down_ready = 4'b0;
    checks++; if (down_valid !== 4'b0) $display("[TB] FAIL stall_drain_all: got %b, expected 0000", down_valid); else passed++;
  endtask

  task automatic test_lane_stall();
    pulse_reset();
    down_ready = 4'b1011;
    for (int n = 0; n < 6; n++) begin
      up_valid = 1'b1;
      up_data  = 8'hC0 + 8'(n);
      #1;
      checks++; if (up_ready !== 1'b1) $display("[TB] FAIL lane_stall_ready beat %0d: got %b, expected 1", n, up_ready); else passed++;
      checks++; if (sel_ptr !== 2'(n % 4)) $display("[TB] FAIL lane_stall_ptr beat %0d: got %0d, expected %0d", n, sel_ptr, n % 4); else passed++;
      tick();
    end
    up_data = 8'hC6;
    for (int h = 0; h < 3; h++) begin
      #1;
      checks++; if (up_ready !== 1'b0) $display("[TB] FAIL lane_stall_blocked_ready: got %b, expected 0", up_ready); else passed++;
      checks++; if (sel_ptr !== 2'd2) $display("[TB] FAIL lane_stall_blocked_ptr: got %0d, expected 2", sel_ptr); else passed++;
      checks++; if (down_data[23:16] !== 8'hC2) $display("[TB] FAIL lane_stall_held_data: got %h, expected c2", down_data[23:16]); else passed++;
      if (h > 0) begin
        checks++; if (down_valid !== 4'b0100) $display("[TB] FAIL lane_stall_no_skip: got %b, expected 0100", down_valid); else passed++;
      end
      tick();
    end
    down_ready = 4'hF;
    #1;
    checks++; if (up_ready !== 1'b1) $display("[TB] FAIL lane_stall_release_ready: got %b, expected 1", up_ready); else passed++;
    tick();
    checks++; if (down_valid !== 4'b0100) $display("[TB] FAIL lane_stall_resume_valid: got %b, expected 0100", down_valid); else passed++;
    checks++; if (down_data[23:16] !== 8'hC6) $display("[TB] FAIL lane_stall_resume_data: got %h, expected c6", down_data[23:16]); else passed++;
    checks++; if (sel_ptr !== 2'd3) $display("[TB] FAIL lane_stall_resume_ptr: got %0d, expected 3", sel_ptr); else passed++;
    up_data = 8'hC7;
    tick();
    up_valid = 1'b0;
    checks++; if (down_valid !== 4'b1000) $display("[TB] FAIL lane_stall_next_valid: got %b, expected 1000", down_valid); else passed++;
    checks++; if (down_data[31:24] !== 8'hC7) $display("[TB] FAIL lane_stall_next_data: got %h, expected c7", down_data[31:24]); else passed++;
    tick();
  endtask

  task automatic test_three_lanes();
    pulse_reset();
    down_ready3 = 3'b111;
    for (int v = 1; v <= 7; v++) begin
      up_valid3 = 1'b1;
      up_data3  = 4'(v);
      #1;
      checks++; if (up_ready3 !== 1'b1) $display("[TB] FAIL n3_ready beat %0d: got %b, expected 1", v, up_ready3); else passed++;
      checks++; if (sel_ptr3 !== 2'((v - 1) % 3)) $display("[TB] FAIL n3_ptr beat %0d: got %0d, expected %0d", v, sel_ptr3, (v - 1) % 3); else passed++;
      tick();
      checks++; if (down_valid3 !== (3'b1 << ((v - 1) % 3))) $display("[TB] FAIL n3_valid beat %0d: got %b, expected %b", v, down_valid3, 3'b1 << ((v - 1) % 3)); else passed++;
      checks++; if (down_data3[((v - 1) % 3)*4 +: 4] !== 4'(v)) $display("[TB] FAIL n3_data beat %0d: got %h, expected %h", v, down_data3[((v - 1) % 3)*4 +: 4], v); else passed++;
    end
    up_valid3 = 1'b0;
    checks++; if (sel_ptr3 !== 2'd1) $display("[TB] FAIL n3_ptr_end: got %0d, expected 1", sel_ptr3); else passed++;
    tick();
  endtask

  task automatic test_reset_midstream();
    pulse_reset();
    down_ready = 4'b0;
    for (int b = 0; b < 4; b++) begin
      up_valid = 1'b1;
      case (b)
        0: up_data = 8'h11;
        1: up_data = 8'h55;
        2: up_data = 8'h22;
        default: up_data = 8'h66;
      endcase
      tick();
    end
    up_valid = 1'b0;
    down_ready = 4'b0101;
    tick();
    down_ready = 4'b0;
    checks++; if (down_valid !== 4'b1010) $display("[TB] FAIL rstmid_before_valid: got %b, expected 1010", down_valid); else passed++;
    checks++; if ({down_data[31:24], down_data[15:8]} !== 16'h6655) $display("[TB] FAIL rstmid_before_data: got %h, expected 6655", {down_data[31:24], down_data[15:8]}); else passed++;
    rst = 1'b1;
    up_valid = 1'b1;
    up_data = 8'h99;
    down_ready = 4'hF;
    tick();
    rst = 1'b0;
    up_valid = 1'b0;
    down_ready = 4'b0;
    checks++; if (down_valid !== 4'b0) $display("[TB] FAIL rstmid_valid: got %b, expected 0000", down_valid); else passed++;
    checks++; if (down_data !== 32'h0) $display("[TB] FAIL rstmid_data: got %h, expected 0", down_data); else passed++;
    checks++; if (sel_ptr !== 2'd0) $display("[TB] FAIL rstmid_ptr: got %0d, expected 0", sel_ptr); else passed++;
    up_valid = 1'b1;
    up_data = 8'h31;
    tick();
    up_valid = 1'b0;
    checks++; if (down_valid !== 4'b0001) $display("[TB] FAIL rstmid_first_valid: got %b, expected 0001", down_valid); else passed++;
    checks++; if (down_data[7:0] !== 8'h31) $display("[TB] FAIL rstmid_first_data: got %h, expected 31", down_data[7:0]); else passed++;
  endtask

  // Scoreboard: one queue of expected beats per lane; beat k goes to lane k mod 4.
  task automatic test_random();
    logic [7:0] exp_q [4][$];
    logic [7:0] prev_data [4];
    logic       prev_hold [4];
    logic       exp_rdy;
    int         k = 0;
    int         cycles = 0;
    int         lane;
    pulse_reset();
    for (int i = 0; i < 4; i++) prev_hold[i] = 1'b0;
    while (k < 2000 && cycles < 20000) begin
      up_valid   = 1'($urandom_range(0, 1));
      up_data    = 8'($urandom);
      down_ready = 4'($urandom);
      #1;
      lane    = k % 4;
      exp_rdy = (exp_q[lane].size() == 0) || down_ready[lane];
      checks++; if (up_ready !== exp_rdy) $display("[TB] FAIL rand_ready beat %0d: got %b, expected %b", k, up_ready, exp_rdy); else passed++;
      checks++; if (sel_ptr !== 2'(lane)) $display("[TB] FAIL rand_ptr beat %0d: got %0d, expected %0d", k, sel_ptr, lane); else passed++;
      for (int i = 0; i < 4; i++) begin
        checks++; if (down_valid[i] !== (exp_q[i].size() != 0)) $display("[TB] FAIL rand_valid lane %0d: got %b, expected %b", i, down_valid[i], exp_q[i].size() != 0); else passed++;
        if (exp_q[i].size() != 0) begin
          checks++; if (down_data[i*8 +: 8] !== exp_q[i][0]) $display("[TB] FAIL rand_data lane %0d: got %h, expected %h", i, down_data[i*8 +: 8], exp_q[i][0]); else passed++;
        end
        if (prev_hold[i]) begin
          checks++; if (down_data[i*8 +: 8] !== prev_data[i]) $display("[TB] FAIL rand_stable lane %0d: got %h, expected %h", i, down_data[i*8 +: 8], prev_data[i]); else passed++;
        end
        prev_hold[i] = (exp_q[i].size() != 0) && !down_ready[i];
        prev_data[i] = down_data[i*8 +: 8];
      end
      for (int i = 0; i < 4; i++) begin
        if (exp_q[i].size() != 0 && down_ready[i]) void'(exp_q[i].pop_front());
      end
      if (up_valid && exp_rdy) begin
        exp_q[lane].push_back(up_data);
        k++;
      end
      tick();
      cycles++;
    end
    up_valid = 1'b0;
    checks++; if (k != 2000) $display("[TB] FAIL rand_budget: got %0d beats, expected 2000", k); else passed++;
    down_ready = 4'hF;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (exp_q[i].size() != 0) begin
        checks++; if (down_data[i*8 +: 8] !== exp_q[i][0]) $display("[TB] FAIL rand_tail lane %0d: got %h, expected %h", i, down_data[i*8 +: 8], exp_q[i][0]); else passed++;
      end
    end
    tick();
    checks++; if (down_valid !== 4'b0) $display("[TB] FAIL rand_final_empty: got %b, expected 0000", down_valid); else passed++;
    down_ready = 4'b0;
  endtask

  initial begin
    $display("[TB] round_robin_demux bench start");
    test_reset();
    test_back_to_back();
    test_all_stalled();
    test_lane_stall();
    test_three_lanes();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
